// File: rtl/hilo_ctrl.sv
// HI/LO register controller sitting behind the Booth multiplier: launches operands,
// waits LATENCY+1 edges, commits the product. Optional unsigned correction: HILO_MULTU_EN.
module hilo_ctrl #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall,
`ifdef HILO_MULTU_EN
  input  logic        is_unsigned,
`endif
  output logic        done
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic             load, capture;
  logic [63:0]      commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = WAIT;
        load    = 1'b1;
      end
      WAIT: if (cnt == '0) begin
        state_n = IDLE;
        capture = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef HILO_MULTU_EN
  logic        uns_flag;
  logic [63:0] uns_prod;

  // Signed product re-weighted to unsigned by adding back each operand's sign-bit term.
  always_comb begin
    uns_prod = mul_z
             + (mul_a[31] ? {mul_b, 32'h0} : 64'h0)
             + (mul_b[31] ? {mul_a, 32'h0} : 64'h0);
    commit   = uns_flag ? uns_prod : mul_z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    uns_flag <= 1'b0;
    else if (load) uns_flag <= is_unsigned;
  end
`else
  assign commit = mul_z;
`endif

  // Operands stay registered until the next accepted start so MULT sees stable inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      mul_a <= '0;
      mul_b <= '0;
      done  <= 1'b0;
    end else begin
      done <= capture;
      if (state == IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
      if (load) begin
        mul_a <= op_a;
        mul_b <= op_b;
        cnt   <= LAT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) {hi, lo} <= commit;
    end
  end

  assign busy  = (state == WAIT);
  assign stall = busy & (start | mthi | mtlo | mfhi | mflo);

  always_comb begin
    rdata = 32'h0;
    if (mfhi)      rdata = hi;
    else if (mflo) rdata = lo;
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: transaction-level HI/LO model compared every cycle,
// plus directed literal expectations. Build with HILO_MULTU_EN to cover the unsigned path.
module tb_hilo_ctrl;

  localparam int LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo, mfhi, mflo, is_unsigned;
  logic [31:0] op_a, op_b, wdata;
  logic [31:0] mul_a, mul_b, rdata;
  logic [63:0] mul_z;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  hilo_ctrl #(.LATENCY(LATENCY), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .busy(busy), .stall(stall),
`ifdef HILO_MULTU_EN
    .is_unsigned(is_unsigned),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Signed multiplier with LATENCY register stages.
  logic [63:0] zpipe [LATENCY];
  always @(posedge clk) begin
    zpipe[0] <= smul(mul_a, mul_b);
    for (int i = 1; i < LATENCY; i++) zpipe[i] <= zpipe[i-1];
  end
  assign mul_z = zpipe[LATENCY-1];

  // Transaction model: a start accepted at cycle k commits its product at cycle k+LATENCY+1.
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [63:0] m_prod = 0;
  logic        m_pend = 0, m_done = 0;
  int          cyc = 0, m_commit = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
      m_pend = 0; m_done = 0;
    end else begin
      cyc++;
      m_done = 0;
      if (m_pend) begin
        if (cyc == m_commit) begin
          {m_hi, m_lo} = m_prod;
          m_pend = 0;
          m_done = 1;
        end
      end else begin
        if (mthi) m_hi = wdata;
        if (mtlo) m_lo = wdata;
        if (start) begin
          m_a = op_a;
          m_b = op_b;
`ifdef HILO_MULTU_EN
          m_prod = is_unsigned ? umul(op_a, op_b) : smul(op_a, op_b);
`else
          m_prod = smul(op_a, op_b);
`endif
          m_commit = cyc + LATENCY + 1;
          m_pend = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", busy, m_pend);
      checkOutput("stall", stall, m_pend & (start | mthi | mtlo | mfhi | mflo));
      checkOutput("done", done, m_done);
      checkOutput("rdata", rdata, mfhi ? m_hi : (mflo ? m_lo : 32'h0));
      checkOutput("mul_a", mul_a, m_a);
      checkOutput("mul_b", mul_b, m_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic wh, input logic wl, input logic [31:0] wd,
                               input logic uns);
    start = s; op_a = a; op_b = b;
    mthi = wh; mtlo = wl; wdata = wd; is_unsigned = uns;
  endtask

  task automatic idle();
    start = 0; mthi = 0; mtlo = 0; mfhi = 0; mflo = 0; is_unsigned = 0;
  endtask

  task automatic readReg(input logic sel_hi, input logic [31:0] exp, input string name);
    mfhi = sel_hi;
    mflo = ~sel_hi;
    @(negedge clk);
    checkOutput(name, rdata, exp);
    tick();
    mfhi = 0;
    mflo = 0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", busy, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_n, done_n, n;
    reset = 0;
    op_a = 0; op_b = 0; wdata = 0;
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_mul_a", mul_a, 32'h0);
    reset = 1;
    tick();
    readReg(1, 32'h0, "rst_hi");

    // 3 * 5
    applyStimulus(1, 32'd3, 32'd5, 0, 0, 0, 0);
    tick();
    idle();
    busy_n = 0; done_n = 0;
    repeat (4) begin
      @(negedge clk);
      busy_n += busy;
      done_n += done;
    end
    checkOutput("busy_cycles", busy_n, LATENCY + 1);
    checkOutput("done_pulses", done_n, 1);
    tick();
    readReg(1, 32'h00000000, "p1_hi");
    readReg(0, 32'h0000000F, "p1_lo");

    // mthi then mfhi in IDLE
    applyStimulus(0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
    tick();
    idle();
    mfhi = 1;
    @(negedge clk);
    checkOutput("mthi_rd", rdata, 32'hDEADBEEF);
    checkOutput("mthi_stall", stall, 1'b0);
    tick();
    idle();

    // -2 * 3 with mflo held from the cycle after start
    applyStimulus(1, 32'hFFFFFFFE, 32'd3, 0, 0, 0, 0);
    tick();
    idle();
    mflo = 1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (!busy) break;
      checkOutput("stall_held", stall, 1'b1);
      checkOutput("rdata_old", rdata, 32'h0000000F);
      n++;
    end
    checkOutput("stall_len", n, LATENCY + 1);
    checkOutput("rdata_new", rdata, 32'hFFFFFFFA);
    checkOutput("stall_rel", stall, 1'b0);
    tick();
    idle();
    readReg(1, 32'hFFFFFFFF, "p2_hi");

    // start while busy must be stalled and ignored
    applyStimulus(1, 32'd7, 32'd9, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'd100, 32'd100, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("busy_start_stall", stall, 1'b1);
    tick();
    idle();
    waitIdle();
    checkOutput("no_relaunch", mul_a, 32'd7);
    readReg(0, 32'd63, "p3_lo");
    readReg(1, 32'd0, "p3_hi");

    // start with mthi+mtlo: product overwrites the write
    applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h12345678, 0);
    tick();
    idle();
    waitIdle();
    readReg(1, 32'h00000000, "p4_hi");
    readReg(0, 32'h00000001, "p4_lo");

    // 0xFFFFFFFF * 2 with is_unsigned requested
    applyStimulus(1, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1);
    tick();
    idle();
    waitIdle();
`ifdef HILO_MULTU_EN
    readReg(1, 32'h00000001, "p5_hi");
`else
    readReg(1, 32'hFFFFFFFF, "p5_hi");
`endif
    readReg(0, 32'hFFFFFFFE, "p5_lo");

    // reset one cycle into a multiply
    applyStimulus(1, 32'd3, 32'd5, 0, 0, 0, 0);
    tick();
    idle();
    @(negedge clk);
    #1 reset = 0;
    #2;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    tick();
    reset = 1;
    done_n = 0;
    repeat (4) begin
      @(negedge clk);
      done_n += done;
    end
    checkOutput("midrst_no_done", done_n, 0);
    tick();
    readReg(1, 32'h0, "midrst_hi");
    readReg(0, 32'h0, "midrst_lo");

    chk_en = 0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
